// File: rtl/hll_pkg.sv
// Shared widths, command encodings and FSM state type for the HyperLogLog bucket engine.
package hll_pkg;

  localparam int unsigned HLL_RARITY_W = 7;
  localparam int unsigned HLL_INDEX_W  = 7;
  localparam int unsigned HLL_RANK_W   = 4;
  localparam int unsigned HLL_SUM_W    = HLL_INDEX_W + HLL_RARITY_W + 2;

  // Harmonic-sum terms are 2^-M scaled up by 2^(rarity width + 1).
  localparam int unsigned HLL_SCALE    = HLL_RARITY_W + 1;

  localparam logic OP_SCAN  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2,
    ST_CLEAR  = 2'd3
  } hll_state_e;

endpackage

// File: rtl/hll_rank_encoder.sv
// Rank of a rarity hash: leading zeros (MSB first) plus one; all-zero gives width+1.
module hll_rank_encoder #(
  parameter int unsigned RARITY_HASH_WIDTH = 7,
  parameter int unsigned RANK_WIDTH        = 4
) (
  input  logic [RARITY_HASH_WIDTH-1:0] rarity_i,
  output logic [RANK_WIDTH-1:0]        rank_c
);

  // Scan from LSB upward so the highest set bit determines the final rank.
  always_comb begin
    rank_c = RANK_WIDTH'(RARITY_HASH_WIDTH + 1);
    for (int unsigned i = 0; i < RARITY_HASH_WIDTH; i++) begin
      if (rarity_i[i]) begin
        rank_c = RANK_WIDTH'(RARITY_HASH_WIDTH - i);
      end
    end
  end

endmodule

// File: rtl/hll_bucket_engine.sv
// HyperLogLog register file: per-bucket max-rank updates, full-array scan producing
// the scaled harmonic sum and zero-bucket count, and single-cycle clear.
module hll_bucket_engine
  import hll_pkg::*;
#(
  parameter int unsigned RARITY_HASH_WIDTH  = HLL_RARITY_W,
  parameter int unsigned BUCKET_INDEX_WIDTH = HLL_INDEX_W,
  parameter int unsigned RANK_WIDTH         = HLL_RANK_W,
  parameter int unsigned SUM_WIDTH          = BUCKET_INDEX_WIDTH + RARITY_HASH_WIDTH + 2
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [BUCKET_INDEX_WIDTH-1:0] upd_address,
  input  logic [RARITY_HASH_WIDTH-1:0]  upd_rarity,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [SUM_WIDTH-1:0]          res_sum,
  output logic [BUCKET_INDEX_WIDTH:0]   res_zeros
);

  localparam int unsigned NUM_BUCKETS = 1 << BUCKET_INDEX_WIDTH;
  localparam int unsigned ZEROS_W     = BUCKET_INDEX_WIDTH + 1;
  localparam int unsigned SCALE       = RARITY_HASH_WIDTH + 1;

  hll_state_e state_q, state_d;

  logic                          s0_valid_q, s0_valid_d;
  logic [BUCKET_INDEX_WIDTH-1:0] s0_addr_q, s0_addr_d;
  logic [RANK_WIDTH-1:0]         s0_rank_q, s0_rank_d;
  logic [RANK_WIDTH-1:0]         rank_c;

  logic [RANK_WIDTH-1:0]         bucket_q [NUM_BUCKETS];
  logic [RANK_WIDTH-1:0]         bucket_d [NUM_BUCKETS];

  logic [BUCKET_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [SUM_WIDTH-1:0]          sum_q, sum_d;
  logic [ZEROS_W-1:0]            zeros_q, zeros_d;
  logic [RANK_WIDTH-1:0]         scan_m_c;
  logic                          clear_all_c;

  hll_rank_encoder #(
    .RARITY_HASH_WIDTH (RARITY_HASH_WIDTH),
    .RANK_WIDTH        (RANK_WIDTH)
  ) u_rank_encoder (
    .rarity_i (upd_rarity),
    .rank_c   (rank_c)
  );

  assign scan_m_c  = bucket_q[idx_q];
  assign res_sum   = sum_q;
  assign res_zeros = zeros_q;

  // Stage 0 captures the accepted update; stage 1 is the bucket write below.
  always_comb begin
    s0_valid_d = upd_valid && upd_ready;
    s0_addr_d  = s0_addr_q;
    s0_rank_d  = s0_rank_q;
    if (upd_valid && upd_ready) begin
      s0_addr_d = upd_address;
      s0_rank_d = rank_c;
    end
  end

  always_comb begin
    bucket_d = bucket_q;
    if (clear_all_c) begin
      for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
        bucket_d[i] = '0;
      end
    end else if (s0_valid_q && (s0_rank_q > bucket_q[s0_addr_q])) begin
      bucket_d[s0_addr_q] = s0_rank_q;
    end
  end

  // Control FSM and scan accumulators.
  always_comb begin
    state_d     = state_q;
    upd_ready   = 1'b0;
    cmd_ready   = 1'b0;
    res_valid   = 1'b0;
    clear_all_c = 1'b0;
    idx_d       = idx_q;
    sum_d       = sum_q;
    zeros_d     = zeros_q;
    case (state_q)
      ST_IDLE: begin
        upd_ready = 1'b1;
        cmd_ready = !s0_valid_q && !upd_valid;
        if (cmd_valid && !s0_valid_q && !upd_valid) begin
          if (cmd_op == OP_CLEAR) begin
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_SCAN;
            idx_d   = '0;
            sum_d   = '0;
            zeros_d = '0;
          end
        end
      end
      ST_SCAN: begin
        sum_d   = sum_q + (SUM_WIDTH'(1) << (RANK_WIDTH'(SCALE) - scan_m_c));
        zeros_d = zeros_q + ZEROS_W'(scan_m_c == '0);
        idx_d   = idx_q + BUCKET_INDEX_WIDTH'(1);
        if (idx_q == '1) begin
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clear_all_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q    <= ST_IDLE;
      s0_valid_q <= 1'b0;
      s0_addr_q  <= '0;
      s0_rank_q  <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      zeros_q    <= '0;
      for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
        bucket_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      s0_valid_q <= s0_valid_d;
      s0_addr_q  <= s0_addr_d;
      s0_rank_q  <= s0_rank_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      zeros_q    <= zeros_d;
      bucket_q   <= bucket_d;
    end
  end

endmodule

// File: doc/hll_bucket_engine.md
# hll_bucket_engine

HyperLogLog register-file engine. It consumes the `{address_hash, rarity_hash}` pairs produced by the per-packet hash stage. For each pair it converts the rarity field to a rank and keeps the per-bucket maximum. On command it scans all buckets and returns the fixed-point harmonic sum and zero-bucket count that the control plane needs for the cardinality estimate.

## Interface
- `RARITY_HASH_WIDTH`, default 7: rarity field width.
- `BUCKET_INDEX_WIDTH`, default 7: bucket address width; there are 2^BUCKET_INDEX_WIDTH buckets.
- `RANK_WIDTH`, default 4: bucket register width; must hold RARITY_HASH_WIDTH+1.
- `SUM_WIDTH`, default BUCKET_INDEX_WIDTH+RARITY_HASH_WIDTH+2: harmonic-sum accumulator width.
- `axis_aclk`, in, 1: the single clock.
- `axis_resetn`, in, 1: reset, asynchronous and active-low.
- `upd_valid`, in, 1: update pair present.
- `upd_ready`, out, 1: update accepted when high together with `upd_valid`.
- `upd_address`, in, BUCKET_INDEX_WIDTH: bucket index.
- `upd_rarity`, in, RARITY_HASH_WIDTH: rarity hash.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command accepted when high together with `cmd_valid`.
- `cmd_op`, in, 1: 0 = SCAN, 1 = CLEAR.
- `res_valid`, out, 1: scan result available.
- `res_ready`, in, 1: result consumed.
- `res_sum`, out, SUM_WIDTH: Σ 2^(RARITY_HASH_WIDTH+1−M[i]), i.e. Σ 2^−M scaled by 2^(RARITY_HASH_WIDTH+1).
- `res_zeros`, out, BUCKET_INDEX_WIDTH+1: number of buckets with M = 0.

## Operation
- Rank: rank = (leading zeros of `upd_rarity`, MSB first) + 1.
  - `upd_rarity` = 0 gives rank RARITY_HASH_WIDTH+1 (8).
  - `upd_rarity` = 7'b1xxxxxx gives rank 1.
- Update pipeline:
  - Stage 0 registers the address and rank on an accepted update.
  - Stage 1 writes M[addr] ← max(M[addr], rank).
  - Buckets are a flop array with combinational read, so back-to-back updates to the same address need no forwarding.
- FSM states: IDLE, SCAN, RESULT, CLEAR.
- IDLE:
  - `upd_ready` = 1.
  - `cmd_ready` = !stage0_valid && !upd_valid. Updates have priority; commands may starve under continuous update traffic, which is accepted.
  - An accepted command goes to SCAN (`cmd_op` = 0) or CLEAR (`cmd_op` = 1).
- SCAN:
  - `upd_ready` = 0 and `cmd_ready` = 0.
  - Index counter runs 0..2^B−1, one bucket per cycle.
  - sum += 1 << (RARITY_HASH_WIDTH+1−M); zeros += (M == 0).
  - Accumulators clear on scan entry.
  - After the last bucket, go to RESULT.
- RESULT:
  - `res_valid` = 1; `res_sum` and `res_zeros` are held stable.
  - Updates and commands are blocked.
  - On `res_valid` && `res_ready`, go to IDLE; `res_valid` drops on the next edge.
- CLEAR: all buckets are set to 0 in one cycle, then IDLE. No result is produced.
- Width rules:
  - Maximum sum is 2^B · 2^(R+1) = 32768 at defaults, which fits SUM_WIDTH = 16.
  - `res_zeros` maximum is 2^B and needs B+1 bits.
  - Index counter wrap from 2^B−1 marks the end of the scan.

## Timing
- Reset values:
  - State IDLE; all buckets 0; stage0_valid 0.
  - `upd_ready` 1, `cmd_ready` 1, `res_valid` 0, `res_sum` 0, `res_zeros` 0.
- Update accepted at edge E: bucket is written at edge E+1, and is visible to a scan started afterwards.
- SCAN accepted at edge E0: bucket i is accumulated at edge E0+1+i; `res_valid` is high from edge E0+2^B (E0+128 at defaults).
- CLEAR accepted at E0: buckets are 0 and the state is IDLE after E0+1.
- `res_ready` held low: RESULT persists indefinitely with outputs unchanged.
- Reset mid-operation: asynchronous return to the reset values.
  - An in-flight scan is discarded.
  - A stage-0 update is dropped.

## Structure
- Package `hll_pkg` holds:
  - default widths;
  - `cmd_op` constants OP_SCAN / OP_CLEAR;
  - FSM state enum;
  - scaling constant RARITY_HASH_WIDTH+1.
- Sub-module `hll_rank_encoder` is a combinational leading-zero count plus one, parameterised on RARITY_HASH_WIDTH.
- The top level holds the pipeline, bucket array, FSM and accumulators.

## Test plan
- Reset, then SCAN → `res_sum` = 32768, `res_zeros` = 128, `res_valid` at accept+128.
- Update addr 5 / rarity 7'b0010000 (rank 3), then SCAN → `res_sum` = 127·256 + 32 = 32544, `res_zeros` = 127.
- Back-to-back updates to addr 5 with rarity 7'b1000000 then 7'b0000000 → M[5] = 8; SCAN → `res_sum` = 32513.
- Update addr 5 with rank 3 then rank 1 → M[5] stays 3; `upd_valid` and `cmd_valid` together → only the update is accepted.
- SCAN with `res_ready` low for 10 cycles → `res_valid` held, values stable, `upd_ready` = 0. Then CLEAR followed by SCAN → 32768 / 128.
- Assert `axis_resetn` at scan bucket 60 → `res_valid` 0, `upd_ready` 1; a following SCAN returns 32768 / 128.
